// File: rtl/dai_tx_multi_if.sv
// Stereo frame handshake between an audio source and dai_tx_multi.
// The source drives the master side and the serializer takes the slave side.
interface dai_tx_multi_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data_l;
    logic [DATA_W-1:0] s_data_r;

    modport master (
        output s_valid,
        output s_data_l,
        output s_data_r,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data_l,
        input  s_data_r,
        output s_ready
    );
endinterface

// File: rtl/dai_tx_multi.sv
// Stereo DAI serializer with frame FIFO, I2S / left-justified framing.
// bclk, lrclk and sdata are all generated by enables in the mclk domain.
module dai_tx_multi #(
    parameter int DATA_W     = 16,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             mclk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             i2s_mode,
    dai_tx_multi_if.slave                    s,
    output logic                             bclk,
    output logic                             lrclk,
    output logic                             sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             underrun
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int IDX_W = $clog2(2*SLOT_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int FRM_W = 2*DATA_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV-1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV/2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2*SLOT_W-1);
    localparam logic [IDX_W-1:0] SLOT_I   = IDX_W'(SLOT_W);
    localparam logic [IDX_W-1:0] DW_I     = IDX_W'(DATA_W);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  pos;
    logic [IDX_W-1:0]  dly;
    logic              mode_q;
    logic              mode_nxt;
    logic [FRM_W-1:0]  frame_q;
    logic [FRM_W-1:0]  frame_nxt;
    logic [DATA_W-1:0] smp;
    logic [DATA_W-1:0] smp_sh;
    logic              left;
    logic              sd_nxt;
    logic              lr_nxt;
    logic              fall;
    logic              boundary;
    logic              push;
    logic              pop;

    logic [FRM_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign fall      = enable && (div_cnt == DIV_LAST);
    assign boundary  = fall && (bit_idx == IDX_LAST);
    assign s.s_ready = fifo_level < LVL_FULL;
    assign push      = s.s_valid && s.s_ready;
    assign pop       = boundary && (fifo_level != '0);

    // Next-state of the bit engine; lrclk/sdata are computed from it
    // so they change on the same edge as the bclk fall.
    always_comb begin
        div_nxt   = '0;
        idx_nxt   = IDX_LAST;
        mode_nxt  = mode_q;
        frame_nxt = frame_q;
        if (enable) begin
            div_nxt = fall ? '0 : div_cnt + 1'b1;
            idx_nxt = bit_idx;
            if (fall) begin
                idx_nxt = boundary ? '0 : bit_idx + 1'b1;
            end
        end
        if (boundary) begin
            mode_nxt  = i2s_mode;
            frame_nxt = pop ? mem[rd_ptr] : '0;
        end
        left   = idx_nxt < SLOT_I;
        k      = left ? idx_nxt : idx_nxt - SLOT_I;
        dly    = {{(IDX_W-1){1'b0}}, mode_nxt};
        pos    = k - dly;
        smp    = left ? frame_nxt[FRM_W-1 -: DATA_W]
                      : frame_nxt[DATA_W-1:0];
        smp_sh = smp << pos;
        sd_nxt = (k >= dly) && (pos < DW_I) && smp_sh[DATA_W-1];
        lr_nxt = mode_nxt ? !left : left;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            bit_idx  <= IDX_LAST;
            mode_q   <= 1'b0;
            frame_q  <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            bit_idx  <= idx_nxt;
            mode_q   <= mode_nxt;
            frame_q  <= frame_nxt;
            bclk     <= div_nxt >= DIV_HALF;
            underrun <= boundary && (fifo_level == '0);
            if (!enable) begin
                lrclk <= 1'b0;
                sdata <= 1'b0;
            end else if (fall) begin
                lrclk <= lr_nxt;
                sdata <= sd_nxt;
            end
        end
    end

    // A pop on an empty FIFO never sees the same-cycle push.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (push) mem[wr_ptr] <= {s.s_data_l, s.s_data_r};
    end
endmodule

// File: tb/tb_dai_tx_multi.sv
// Directed bench for dai_tx_multi: framing, FIFO, underrun and reset.
// Bits are captured on bclk rise, sampled at mclk falling edges.
module tb_dai_tx_multi;
    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 8;
    localparam int FIFO_DEPTH = 4;

    logic       mclk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       i2s_mode = 1'b0;
    logic       bclk;
    logic       lrclk;
    logic       sdata;
    logic       underrun;
    logic [2:0] fifo_level;

    dai_tx_multi_if #(.DATA_W(DATA_W)) s_if ();

    dai_tx_multi #(
        .DATA_W(DATA_W),
        .SLOT_W(SLOT_W),
        .BCLK_DIV(BCLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .mclk(mclk),
        .reset_n(reset_n),
        .enable(enable),
        .i2s_mode(i2s_mode),
        .s(s_if),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .fifo_level(fifo_level),
        .underrun(underrun)
    );

    always #5 mclk = ~mclk;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int last_gap = 0;
    logic [63:0] cap_sd;
    logic [63:0] cap_lr;

    localparam logic [63:0] ONES_L = {32'hFFFF_FFFF, 32'h0};
    localparam logic [63:0] ONES_R = {32'h0, 32'hFFFF_FFFF};

    task automatic wait_rise(output int gap, output bit ok);
        logic prev;
        gap = 0;
        ok = 1'b0;
        for (int i = 0; i < 4*BCLK_DIV; i++) begin
            prev = bclk;
            @(negedge mclk);
            gap++;
            if (!prev && bclk) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic capture(input int n);
        int gap;
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_rise(gap, ok);
            if (!ok) begin
                chk_cnt++;
                $display("FAIL bclk_timeout got no rise need rise");
                return;
            end
            last_gap = gap;
            cap_sd = {cap_sd[62:0], sdata};
            cap_lr = {cap_lr[62:0], lrclk};
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        s_if.s_valid = 1'b0;
        @(negedge mclk);
        reset_n = 1'b0;
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        s_if.s_valid = 1'b1;
        s_if.s_data_l = l;
        s_if.s_data_r = r;
        @(negedge mclk);
        s_if.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge mclk);
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (bclk !== 1'b0) $display("FAIL rst_bclk got %b need 0", bclk);
        else pass_cnt++;
        chk_cnt++;
        if (lrclk !== 1'b0) $display("FAIL rst_lrclk got %b need 0", lrclk);
        else pass_cnt++;
        chk_cnt++;
        if (sdata !== 1'b0) $display("FAIL rst_sdata got %b need 0", sdata);
        else pass_cnt++;
        chk_cnt++;
        if (underrun !== 1'b0) $display("FAIL rst_underrun got %b need 0", underrun);
        else pass_cnt++;
        chk_cnt++;
        if (s_if.s_ready !== 1'b1) $display("FAIL rst_ready got %b need 1", s_if.s_ready);
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd0) $display("FAIL rst_level got %0d need 0", fifo_level);
        else pass_cnt++;
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_left_justified();
        do_reset();
        i2s_mode = 1'b0;
        push(16'hA5C3, 16'h8001);
        chk_cnt++;
        if (fifo_level !== 3'd1) $display("FAIL lj_level_push got %0d need 1", fifo_level);
        else pass_cnt++;
        enable = 1'b1;
        repeat (8) @(negedge mclk);
        chk_cnt++;
        if (underrun !== 1'b0) $display("FAIL lj_no_underrun got %b need 0", underrun);
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd0) $display("FAIL lj_level_pop got %0d need 0", fifo_level);
        else pass_cnt++;
        cap_sd = '0;
        cap_lr = '0;
        capture(64);
        chk_cnt++;
        if (last_gap !== 8) $display("FAIL lj_bclk_period got %0d need 8", last_gap);
        else pass_cnt++;
        chk_cnt++;
        if (cap_sd !== {16'hA5C3, 16'h0, 16'h8001, 16'h0})
            $display("FAIL lj_sdata got %h need %h", cap_sd, {16'hA5C3, 16'h0, 16'h8001, 16'h0});
        else pass_cnt++;
        chk_cnt++;
        if (cap_lr !== ONES_L) $display("FAIL lj_lrclk got %h need %h", cap_lr, ONES_L);
        else pass_cnt++;
        enable = 1'b0;
    endtask

    task automatic test_i2s();
        logic [63:0] exp_sd;
        exp_sd = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0};
        do_reset();
        i2s_mode = 1'b1;
        push(16'hA5C3, 16'h8001);
        enable = 1'b1;
        repeat (8) @(negedge mclk);
        cap_sd = '0;
        cap_lr = '0;
        capture(64);
        chk_cnt++;
        if (cap_sd !== exp_sd) $display("FAIL i2s_sdata got %h need %h", cap_sd, exp_sd);
        else pass_cnt++;
        chk_cnt++;
        if (cap_lr !== ONES_R) $display("FAIL i2s_lrclk got %h need %h", cap_lr, ONES_R);
        else pass_cnt++;
        enable = 1'b0;
        i2s_mode = 1'b0;
    endtask

    task automatic test_underrun();
        int cnt;
        logic any_sd;
        logic any_ur;
        do_reset();
        i2s_mode = 1'b0;
        enable = 1'b1;
        repeat (7) @(negedge mclk);
        chk_cnt++;
        if (underrun !== 1'b0) $display("FAIL ur_early got %b need 0", underrun);
        else pass_cnt++;
        @(negedge mclk);
        chk_cnt++;
        if (underrun !== 1'b1) $display("FAIL ur_first_pulse got %b need 1", underrun);
        else pass_cnt++;
        cnt = 0;
        any_sd = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge mclk);
            cnt++;
            any_sd = any_sd | sdata;
            if (underrun === 1'b1) break;
        end
        chk_cnt++;
        if (cnt !== 512) $display("FAIL ur_period got %0d need 512", cnt);
        else pass_cnt++;
        chk_cnt++;
        if (any_sd !== 1'b0) $display("FAIL ur_sdata_idle got %b need 0", any_sd);
        else pass_cnt++;
        repeat (100) @(negedge mclk);
        push(16'h1234, 16'hFEDC);
        cnt = 101;
        any_ur = 1'b0;
        while (cnt < 512) begin
            @(negedge mclk);
            cnt++;
            any_ur = any_ur | underrun;
        end
        chk_cnt++;
        if (any_ur !== 1'b0) $display("FAIL ur_refill_pulse got %b need 0", any_ur);
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd0) $display("FAIL ur_refill_pop got %0d need 0", fifo_level);
        else pass_cnt++;
        cap_sd = '0;
        cap_lr = '0;
        capture(64);
        chk_cnt++;
        if (cap_sd !== {16'h1234, 16'h0, 16'hFEDC, 16'h0})
            $display("FAIL ur_refill_data got %h need %h", cap_sd, {16'h1234, 16'h0, 16'hFEDC, 16'h0});
        else pass_cnt++;
        enable = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [15:0] tl [5];
        logic [15:0] tr [5];
        logic [63:0] exp_sd;
        tl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        tr = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        do_reset();
        i2s_mode = 1'b0;
        for (int i = 0; i < 4; i++) push(tl[i], tr[i]);
        chk_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL full_level got %0d need 4", fifo_level);
        else pass_cnt++;
        chk_cnt++;
        if (s_if.s_ready !== 1'b0) $display("FAIL full_ready got %b need 0", s_if.s_ready);
        else pass_cnt++;
        s_if.s_valid = 1'b1;
        s_if.s_data_l = tl[4];
        s_if.s_data_r = tr[4];
        repeat (3) @(negedge mclk);
        chk_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL full_hold got %0d need 4", fifo_level);
        else pass_cnt++;
        enable = 1'b1;
        repeat (7) @(negedge mclk);
        chk_cnt++;
        if (s_if.s_ready !== 1'b0) $display("FAIL full_ready_prepop got %b need 0", s_if.s_ready);
        else pass_cnt++;
        @(negedge mclk);
        chk_cnt++;
        if (s_if.s_ready !== 1'b1) $display("FAIL full_ready_pop got %b need 1", s_if.s_ready);
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd3) $display("FAIL full_level_pop got %0d need 3", fifo_level);
        else pass_cnt++;
        @(negedge mclk);
        chk_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL full_level_refill got %0d need 4", fifo_level);
        else pass_cnt++;
        s_if.s_valid = 1'b0;
        cap_sd = '0;
        cap_lr = '0;
        for (int f = 0; f < 5; f++) begin
            exp_sd = {tl[f], 16'h0, tr[f], 16'h0};
            capture(64);
            chk_cnt++;
            if (cap_sd !== exp_sd) $display("FAIL full_order_%0d got %h need %h", f, cap_sd, exp_sd);
            else pass_cnt++;
        end
        enable = 1'b0;
    endtask

    task automatic test_mode_change();
        logic [63:0] exp2;
        exp2 = {1'b0, 16'h4C2B, 15'h0, 1'b0, 16'hF00F, 15'h0};
        do_reset();
        i2s_mode = 1'b0;
        push(16'hA5C3, 16'h8001);
        push(16'h4C2B, 16'hF00F);
        enable = 1'b1;
        repeat (8) @(negedge mclk);
        cap_sd = '0;
        cap_lr = '0;
        capture(10);
        i2s_mode = 1'b1;
        capture(54);
        chk_cnt++;
        if (cap_sd !== {16'hA5C3, 16'h0, 16'h8001, 16'h0})
            $display("FAIL mode_cur_sdata got %h need %h", cap_sd, {16'hA5C3, 16'h0, 16'h8001, 16'h0});
        else pass_cnt++;
        chk_cnt++;
        if (cap_lr !== ONES_L) $display("FAIL mode_cur_lrclk got %h need %h", cap_lr, ONES_L);
        else pass_cnt++;
        capture(64);
        chk_cnt++;
        if (cap_sd !== exp2) $display("FAIL mode_next_sdata got %h need %h", cap_sd, exp2);
        else pass_cnt++;
        chk_cnt++;
        if (cap_lr !== ONES_R) $display("FAIL mode_next_lrclk got %h need %h", cap_lr, ONES_R);
        else pass_cnt++;
        enable = 1'b0;
        i2s_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i2s_mode = 1'b0;
        push(16'h0F0F, 16'h7001);
        push(16'h1357, 16'h2468);
        enable = 1'b1;
        repeat (8) @(negedge mclk);
        cap_sd = '0;
        cap_lr = '0;
        capture(40);
        repeat (4) @(negedge mclk);
        chk_cnt++;
        if (cap_sd[39:0] !== {16'h0F0F, 16'h0, 8'h70})
            $display("FAIL rmid_partial got %h need %h", cap_sd[39:0], {16'h0F0F, 16'h0, 8'h70});
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd1) $display("FAIL rmid_level_pre got %0d need 1", fifo_level);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bclk, lrclk, sdata} !== 3'b000)
            $display("FAIL rmid_outputs got %b need 000", {bclk, lrclk, sdata});
        else pass_cnt++;
        chk_cnt++;
        if (fifo_level !== 3'd0) $display("FAIL rmid_level got %0d need 0", fifo_level);
        else pass_cnt++;
        chk_cnt++;
        if (s_if.s_ready !== 1'b1) $display("FAIL rmid_ready got %b need 1", s_if.s_ready);
        else pass_cnt++;
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (7) @(negedge mclk);
        chk_cnt++;
        if ({underrun, lrclk} !== 2'b00)
            $display("FAIL rmid_pre_frame got %b need 00", {underrun, lrclk});
        else pass_cnt++;
        @(negedge mclk);
        chk_cnt++;
        if ({underrun, lrclk, sdata} !== 3'b110)
            $display("FAIL rmid_first_frame got %b need 110", {underrun, lrclk, sdata});
        else pass_cnt++;
        enable = 1'b0;
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data_l = '0;
        s_if.s_data_r = '0;
        test_reset();
        test_left_justified();
        test_i2s();
        test_underrun();
        test_fifo_full();
        test_mode_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dai_tx_multi.md
Name: dai_tx_multi

Overview:
- Parametrised successor to the fixed 16-bit stereo serializer.
- Generates bclk/lrclk and serial data from the single mclk domain using clock-enable counters. No derived-clock flops.
- Accepts stereo frames through a valid/ready FIFO instead of addressing a ROM.
- Supports I2S and left-justified framing, configurable sample/slot width, and flags underruns. Sits between an audio source (ROM reader, DMA, mixer) and the external DAC.

Parameters:
- DATA_W, 16: sample width per channel in bits. Range 8..32.
- SLOT_W, 32: bclk periods per channel slot. Must satisfy SLOT_W > DATA_W.
- BCLK_DIV, 8: mclk cycles per bclk period. Even, >= 2.
- FIFO_DEPTH, 4: stereo frames buffered. Power of 2, >= 2.

Ports:
- mclk, in, 1: master clock. The only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run serializer. When 0, the serial interface idles.
- i2s_mode, in, 1: 1 = I2S (1-bit delay, lrclk low = left); 0 = left-justified (no delay, lrclk high = left).
- s_valid, in, 1: frame valid.
- s_ready, out, 1: FIFO not full.
- s_data_l, in, DATA_W: left sample, two's complement.
- s_data_r, in, DATA_W: right sample.
- bclk, out, 1: bit clock to DAC. DAC samples on the rising edge.
- lrclk, out, 1: word select.
- sdata, out, 1: serial data, MSB first.
- fifo_level, out, $clog2(FIFO_DEPTH+1): frames stored.
- underrun, out, 1: one-mclk pulse when a frame boundary finds the FIFO empty.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - bclk=0, lrclk=0, sdata=0, underrun=0.
  - FIFO emptied: fifo_level=0, s_ready=1.
  - div_cnt=0, bit_idx=2*SLOT_W-1, frame shift register cleared.
- Reset mid-frame: the partial frame and all FIFO contents are discarded.
- Divider:
  - While enable=1, div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk=1 when div_cnt >= BCLK_DIV/2, else 0. All outputs are registered.
  - Fall event = the mclk edge at which div_cnt wraps BCLK_DIV-1 -> 0. On that edge bclk goes 0, and lrclk and sdata update on the same edge.
- Bit index:
  - bit_idx increments on each fall event, modulo 2*SLOT_W.
  - Left slot is bit_idx 0..SLOT_W-1; right slot is SLOT_W..2*SLOT_W-1.
- Frame boundary (fall event where bit_idx wraps to 0):
  - i2s_mode is latched into mode_q. A mid-frame change has no effect until the next boundary.
  - If fifo_level > 0: pop the head and load {s_data_l, s_data_r} into the shift register.
  - If fifo_level = 0: load all zeros and pulse underrun for exactly one mclk.
- lrclk:
  - mode_q=0 (left-justified): 1 during the left slot, 0 during the right slot.
  - mode_q=1 (I2S): 0 during the left slot, 1 during the right slot.
- sdata within a slot, at slot position k (k = bit_idx mod SLOT_W), with d = mode_q:
  - k < d: output 0.
  - d <= k < d+DATA_W: output sample bit DATA_W-1-(k-d).
  - otherwise: output 0 (padding).
  - SLOT_W > DATA_W guarantees the I2S delay bit and the trailing pad are always zero.
- First frame after enable 0->1: bit_idx starts at 2*SLOT_W-1, so the first fall event (BCLK_DIV cycles after enable) is a frame boundary.
- enable=0:
  - div_cnt and bit_idx are held at their reset values.
  - bclk=0, lrclk=0, sdata=0.
  - The FIFO still accepts pushes. The in-flight frame is abandoned (not re-queued).
- FIFO:
  - Push when s_valid && s_ready. s_ready = (fifo_level < FIFO_DEPTH), derived combinationally from registered level.
  - Push and pop in the same cycle: level unchanged.
  - Pop on an empty FIFO never bypasses a same-cycle push. The push is stored and the frame underruns.
  - Pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- Frame period = 2*SLOT_W*BCLK_DIV mclk cycles. Defaults: 512 mclk, 64 bclk per frame.

Test Plan:
- Reset: drive reset_n=0 asynchronously between mclk edges -> bclk=0, lrclk=0, sdata=0, underrun=0, s_ready=1, fifo_level=0 immediately.
- Left-justified, defaults: push L=16'hA5C3, R=16'h8001, then enable=1.
  - bclk period 8 mclk; lrclk=1 for 32 bclk.
  - Bits captured on bclk rise: 1010010111000011 followed by 16 zeros.
  - Then lrclk=0, bits: 1000000000000001 followed by 16 zeros.
- I2S: same data, i2s_mode=1 -> lrclk=0 for the left slot; first bit 0, then A5C3 MSB-first, then 15 zeros. Right slot likewise: 0, 8001, 15 zeros.
- Underrun: enable with an empty FIFO -> sdata stays 0; underrun pulses 1 mclk every 512 mclk. Push a frame mid-frame -> it is sent at the next boundary with no pulse.
- FIFO full: enable=0, push 4 frames -> fifo_level=4, s_ready=0, 5th s_valid held. Enable -> frames emerge in push order; s_ready rises 1 cycle after the first pop.
- Mode change and reset mid-frame:
  - Toggle i2s_mode at bit_idx=10 -> the current frame is unchanged and the new framing starts at the next boundary.
  - Pulse reset_n low at bit_idx=40 -> outputs 0 and FIFO empty. After release with enable=1, the first frame starts 8 mclk later with an underrun pulse.
